grasspopper_arbiter: RTL and testbench
======================================

# grasspopper_arbiter

Round-robin arbiter that shares one `grasspopper` cipher core among `N_REQ` independent requesters. Each requester hands over a 128-bit block with a valid/ready handshake. The arbiter sequences the core's request/valid/ack protocol for the winning requester and returns the result, or a timeout error, on that requester's response channel. It sits between the client logic and the single `grasspopper` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1024: maximum number of cycles in WAIT before an error is reported, ≥ 2.
- `clk`  in  1: clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid_i`  in  N_REQ: requester i has a block to cipher.
- `req_data_i`  in  N_REQ*128: block of requester i, in bits [i*128 +: 128].
- `req_ready_o`  out  N_REQ: one-hot acceptance strobe.
- `rsp_valid_o`  out  N_REQ: one-hot, result available for requester i.
- `rsp_data_o`  out  128: result data, shared by all requesters.
- `rsp_err_o`  out  1: result is a timeout error; qualified by `rsp_valid_o`.
- `rsp_ready_i`  in  N_REQ: requester i consumes its result.
- `core_data_o`  out  128: connects to core `data_i`.
- `core_request_o`  out  1: connects to core `request_i`.
- `core_ack_o`  out  1: connects to core `ack_i`.
- `core_data_i`  in  128: connects to core `data_o`.
- `core_valid_i`  in  1: connects to core `valid_o`.
- `core_busy_i`  in  1: connects to core `busy_o`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK, RESP.
- IDLE:
  - If `core_busy_i`=0 and any `req_valid_i` is set, the winner g is the first set bit searching upward from `ptr`, wrapping modulo N_REQ.
  - `req_ready_o[g]`=1 combinationally in this cycle. All other requesters see 0.
  - `req_data_i[g]` is latched into the operand register, g is latched into `grant`, and the FSM moves to ISSUE.
  - If `core_busy_i`=1, no grant is made and `req_ready_o` stays all zero.
- ISSUE:
  - `core_request_o`=1 for exactly this one cycle.
  - `core_data_o` is driven from the operand register, which is held stable from ISSUE through ACK.
  - Next state is WAIT, and the timeout counter is cleared.
- WAIT:
  - The counter increments each cycle.
  - If `core_valid_i`=1: latch `core_data_i` into the result register, clear the error flag, go to ACK.
  - Otherwise, when the counter reaches TIMEOUT-1: clear the result register, set the error flag, go to RESP. `core_ack_o` is not issued on this path.
  - If `core_valid_i` arrives in the same cycle as expiry, valid wins.
- ACK: `core_ack_o`=1 for exactly one cycle, then go to RESP.
- RESP:
  - `rsp_valid_o[grant]`=1, `rsp_data_o` is driven from the result register, and `rsp_err_o` from the error flag.
  - These are held until `rsp_ready_i[grant]`=1.
  - On that handshake: `ptr` ← (grant+1) mod N_REQ, and the FSM returns to IDLE.
- Ignored inputs:
  - `rsp_ready_i` bits of non-granted requesters.
  - `core_valid_i` outside WAIT.
  - `req_valid_i` outside IDLE.
- A requester may drop `req_valid_i` at any time before its acceptance without side effects.
- Exactly one block is in flight at a time; there is no queueing.

## Timing
- Reset values:
  - State IDLE, `ptr`=0, `grant`=0, counter 0.
  - Operand, result and error registers cleared.
  - All outputs 0: `req_ready_o`, `rsp_valid_o`, `rsp_data_o`, `rsp_err_o`, `core_*_o`.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. No ack is sent to the core; the core is reset by the same `rst`.
- Latency sequence:
  - Acceptance in cycle T.
  - `core_request_o` in T+1.
  - WAIT from T+2.
  - First `core_valid_i` in cycle V gives `core_ack_o` in V+1 and `rsp_valid_o` in V+2.
- Timeout: the error response appears TIMEOUT+2 cycles after acceptance.
- Back-to-back: after the RESP handshake in cycle R, the next acceptance is possible in R+1.
- Registered vs combinational:
  - `core_request_o`, `core_ack_o`, `rsp_valid_o`, `rsp_data_o` and `rsp_err_o` are decoded from registered state only.
  - `req_ready_o` is the only combinational output.

## Test plan
- Single request: requester 2, data 128'hc177d2d35af6d17477545bfcf97d43a4; core model returns ~data 10 cycles after request. Required response:
  - `req_ready_o`=4'b0100 for one cycle.
  - `core_request_o` one cycle later.
  - `rsp_valid_o`=4'b0100 with ~data, `rsp_err_o`=0, two cycles after core valid.
  - Exactly one `core_ack_o` pulse.
- All four requesters held valid continuously: grants in order 0,1,2,3,0. Each response carries its own requester's result. No `core_request_o` while a previous block is unacked.
- `core_busy_i` forced high for 50 cycles with `req_valid_i`=4'b0001: `req_ready_o` stays 0 throughout. Acceptance occurs in the first cycle busy is low.
- Core model never asserts valid, TIMEOUT=16: `rsp_valid_o` asserts with `rsp_err_o`=1 and `rsp_data_o`=0, 18 cycles after acceptance. `core_ack_o` never pulses.
- Back-pressure: `rsp_ready_i` held low for 20 cycles. `rsp_valid_o`, `rsp_data_o` and `rsp_err_o` stay stable and no new grant occurs. Releasing ready gives IDLE the next cycle.
- Reset asserted during WAIT: the next cycle has all outputs 0 and `ptr`=0. A subsequent request from requester 0 completes normally.

Source files
------------

// File: rtl/grasspopper_arbiter_if.sv
// Bundle of requester-side and core-side signals around the grasspopper arbiter.
// The arbiter connects through the slave modport; client/core logic uses master.
interface grasspopper_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]     req_valid_i;
    logic [N_REQ*128-1:0] req_data_i;
    logic [N_REQ-1:0]     req_ready_o;
    logic [N_REQ-1:0]     rsp_valid_o;
    logic [127:0]         rsp_data_o;
    logic                 rsp_err_o;
    logic [N_REQ-1:0]     rsp_ready_i;
    logic [127:0]         core_data_o;
    logic                 core_request_o;
    logic                 core_ack_o;
    logic [127:0]         core_data_i;
    logic                 core_valid_i;
    logic                 core_busy_i;

    modport slave (
        input  req_valid_i, req_data_i, rsp_ready_i,
        input  core_data_i, core_valid_i, core_busy_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output core_data_o, core_request_o, core_ack_o
    );

    modport master (
        output req_valid_i, req_data_i, rsp_ready_i,
        output core_data_i, core_valid_i, core_busy_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  core_data_o, core_request_o, core_ack_o
    );
endinterface

// File: rtl/grasspopper_arbiter.sv
// Round-robin arbiter sharing one grasspopper cipher core among N_REQ requesters,
// with a per-block timeout that turns a silent core into an error response.
module grasspopper_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic rst,
    grasspopper_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant;
    logic [CNT_W-1:0]   count;
    logic [127:0]       operand;
    logic [127:0]       result;
    logic               err_flag;
    logic               core_request_q;
    logic               core_ack_q;
    logic [N_REQ-1:0]   rsp_valid_q;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    int                 j;

    // Search upward from ptr with wrap; the first requesting index wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        j         = 0;
        if (state == IDLE && !bus.core_busy_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = int'(ptr) + k;
                if (j >= N_REQ) begin
                    j = j - N_REQ;
                end
                cand = PTR_W'(j);
                if (!win_found && bus.req_valid_i[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    assign bus.req_ready_o    = win_found ? (ONE_HOT0 << win_idx) : '0;
    assign bus.core_data_o    = operand;
    assign bus.core_request_o = core_request_q;
    assign bus.core_ack_o     = core_ack_q;
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_data_o     = result;
    assign bus.rsp_err_o      = err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            grant          <= '0;
            count          <= '0;
            operand        <= '0;
            result         <= '0;
            err_flag       <= 1'b0;
            core_request_q <= 1'b0;
            core_ack_q     <= 1'b0;
            rsp_valid_q    <= '0;
        end else begin
            core_request_q <= 1'b0;
            core_ack_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        operand        <= bus.req_data_i[int'(win_idx)*128 +: 128];
                        grant          <= win_idx;
                        core_request_q <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    count <= count + 1'b1;
                    // A valid arriving on the expiry cycle still counts as a result.
                    if (bus.core_valid_i) begin
                        result     <= bus.core_data_i;
                        err_flag   <= 1'b0;
                        core_ack_q <= 1'b1;
                        state      <= ACK;
                    end else if (count == CNT_LAST) begin
                        result      <= '0;
                        err_flag    <= 1'b1;
                        rsp_valid_q <= ONE_HOT0 << grant;
                        state       <= RESP;
                    end
                end
                ACK: begin
                    rsp_valid_q <= ONE_HOT0 << grant;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready_i[grant]) begin
                        rsp_valid_q <= '0;
                        ptr         <= (grant == PTR_LAST) ? '0 : grant + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_grasspopper_arbiter.sv
// Scoreboard bench for grasspopper_arbiter: a round-robin reference model predicts
// grants and responses; a monitor and a behavioural core run alongside the stimulus.
module tb_grasspopper_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int PW = $clog2(N);

    typedef struct {
        int           id;
        logic [127:0] data;
        logic         err;
        int           first;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grasspopper_arbiter_if #(.N_REQ(N)) bus ();

    grasspopper_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rsp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [127:0] req_data [N];
    int           m_ptr = 0;
    bit           m_idle = 1'b1;
    int           m_id = 0;
    int           m_first = 0;
    int           m_accepts = 0;
    int           core_delay = 10;
    bit           rand_delay = 1'b0;
    int           exp_req_cyc = -1;
    int           exp_acks = 0;
    int           acks_seen = 0;
    bit           pending = 1'b0;
    int           rc = 0;
    logic [127:0] cdata = '0;
    bit           have_cur = 1'b0;
    rsp_t         cur;
    logic [N-1:0] last_valid;
    logic [127:0] last_data;
    logic         last_err;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int pick(input int p, input logic [N-1:0] v);
        logic [PW-1:0] sel;
        for (int k = 0; k < N; k++) begin
            sel = PW'((p + k) % N);
            if (v[sel]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, predict the grant, then check and advance the model.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic busy, input logic [N-1:0] rready);
        int           win;
        logic [N-1:0] exp_ready;
        rsp_t         e;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.req_valid_i = valid;
        bus.core_busy_i = busy;
        bus.rsp_ready_i = rready;
        for (int i = 0; i < N; i++) bus.req_data_i[i*128 +: 128] = req_data[i];
        win       = -1;
        exp_ready = '0;
        if (m_idle && !busy && valid != '0) begin
            win       = pick(m_ptr, valid);
            exp_ready = N'(1) << win;
        end
        @(negedge clk);
        checkOutput("req_ready", 128'(bus.req_ready_o), 128'(exp_ready));
        if (win >= 0) begin
            if (rand_delay) core_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TO));
            e.id = win;
            if (core_delay >= 1 && core_delay <= TO) begin
                e.data  = ~req_data[win];
                e.err   = 1'b0;
                e.first = cyc + core_delay + 3;
                exp_acks++;
            end else begin
                e.data  = '0;
                e.err   = 1'b1;
                e.first = cyc + TO + 2;
            end
            sb.push_back(e);
            m_idle      = 1'b0;
            m_id        = win;
            m_first     = e.first;
            m_accepts++;
            exp_req_cyc = cyc + 1;
            req_data[win] = rand128();
        end else if (!m_idle && cyc >= m_first && rready[m_id]) begin
            m_idle = 1'b1;
            m_ptr  = (m_id + 1) % N;
        end
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst             = 1'b1;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '0;
        bus.core_busy_i = 1'b0;
        @(negedge clk);
        sb.delete();
        m_idle      = 1'b1;
        m_ptr       = 0;
        exp_acks    = 0;
        acks_seen   = 0;
        exp_req_cyc = -1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, 128'(bus.rsp_valid_o), 128'(0));
        checkOutput({tag, "_rsp_data"}, bus.rsp_data_o, 128'(0));
        checkOutput({tag, "_rsp_err"}, 128'(bus.rsp_err_o), 128'(0));
        checkOutput({tag, "_core_req"}, 128'(bus.core_request_o), 128'(0));
        checkOutput({tag, "_core_ack"}, 128'(bus.core_ack_o), 128'(0));
        checkOutput({tag, "_core_data"}, bus.core_data_o, 128'(0));
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 200;
        while (!(m_idle && sb.size() == 0) && budget > 0) begin
            applyStimulus('0, 1'b0, '1);
            budget--;
        end
        checkOutput({tag, "_outstanding"}, 128'(sb.size()), 128'(0));
        checkOutput({tag, "_ack_count"}, 128'(acks_seen), 128'(exp_acks));
    endtask

    task automatic monitor_loop();
        logic [N-1:0] exp_valid;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_cur = 1'b0;
            end else if (bus.rsp_valid_o != '0) begin
                if (have_cur) begin
                    checkOutput("rsp_hold_valid", 128'(bus.rsp_valid_o), 128'(last_valid));
                    checkOutput("rsp_hold_data", bus.rsp_data_o, last_data);
                    checkOutput("rsp_hold_err", 128'(bus.rsp_err_o), 128'(last_err));
                end else if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 128'(bus.rsp_valid_o), 128'(0));
                end else begin
                    cur       = sb[0];
                    have_cur  = 1'b1;
                    exp_valid = N'(1) << cur.id;
                    checkOutput("rsp_valid", 128'(bus.rsp_valid_o), 128'(exp_valid));
                    checkOutput("rsp_data", bus.rsp_data_o, cur.data);
                    checkOutput("rsp_err", 128'(bus.rsp_err_o), 128'(cur.err));
                    checkOutput("rsp_latency", 128'(cyc), 128'(cur.first));
                    last_valid = bus.rsp_valid_o;
                    last_data  = bus.rsp_data_o;
                    last_err   = bus.rsp_err_o;
                end
                if (have_cur && (bus.rsp_valid_o & bus.rsp_ready_i) != '0) begin
                    void'(sb.pop_front());
                    have_cur = 1'b0;
                end
            end
        end
    endtask

    // Behavioural core: answers ~data core_delay cycles after a request, holds valid until ack.
    task automatic core_loop();
        forever begin
            @(posedge clk);
            #1;
            if (pending && cyc >= rc + core_delay) begin
                bus.core_valid_i = 1'b1;
                bus.core_data_i  = ~cdata;
            end else begin
                bus.core_valid_i = 1'b0;
                bus.core_data_i  = rand128();
            end
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (bus.core_request_o) begin
                    checkOutput("core_req_overlap", 128'(pending), 128'(0));
                    checkOutput("core_req_cycle", 128'(cyc), 128'(exp_req_cyc));
                    if (core_delay >= 1) begin
                        pending = 1'b1;
                        rc      = cyc;
                        cdata   = bus.core_data_o;
                    end
                end
                if (bus.core_ack_o) begin
                    acks_seen++;
                    pending = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        int start;
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.rsp_ready_i  = '0;
        bus.core_busy_i  = 1'b0;
        bus.core_valid_i = 1'b0;
        bus.core_data_i  = '0;
        for (int i = 0; i < N; i++) req_data[i] = rand128();
        fork
            monitor_loop();
            core_loop();
        join_none

        repeat (2) @(posedge clk);
        applyStimulus('0, 1'b0, '0);
        check_idle_outputs("reset");

        $display("[TB] single request from requester 2");
        req_data[2] = 128'hc177d2d35af6d17477545bfcf97d43a4;
        core_delay  = 10;
        applyStimulus(4'b0100, 1'b0, '1);
        drain("single");
        checkOutput("single_one_ack", 128'(acks_seen), 128'(1));

        $display("[TB] all requesters held valid");
        reset_cycle();
        core_delay = 3;
        start      = m_accepts;
        budget     = 300;
        while (m_accepts < start + 5 && budget > 0) begin
            applyStimulus(4'b1111, 1'b0, '1);
            budget--;
        end
        checkOutput("all_valid_grants", 128'(m_accepts - start), 128'(5));
        drain("all_valid");

        $display("[TB] core busy blocks grants");
        core_delay = 4;
        repeat (50) applyStimulus(4'b0001, 1'b1, '1);
        applyStimulus(4'b0001, 1'b0, '1);
        drain("busy");

        $display("[TB] timeout and expiry-cycle valid");
        core_delay = -1;
        applyStimulus(4'b0010, 1'b0, '1);
        drain("timeout");
        core_delay = TO;
        applyStimulus(4'b0100, 1'b0, '1);
        drain("late_valid");

        $display("[TB] response back-pressure");
        core_delay = 5;
        applyStimulus(4'b1000, 1'b0, '0);
        repeat (28) applyStimulus(4'b1111, 1'b0, '0);
        applyStimulus(4'b1111, 1'b0, '1);
        applyStimulus(4'b1111, 1'b0, '1);
        drain("backpressure");

        $display("[TB] reset during WAIT");
        core_delay = 2;
        applyStimulus(4'b0010, 1'b0, '1);
        drain("pre_reset");
        core_delay = -1;
        applyStimulus(4'b1000, 1'b0, '1);
        repeat (4) applyStimulus('0, 1'b0, '1);
        reset_cycle();
        applyStimulus('0, 1'b0, '0);
        check_idle_outputs("midreset");
        core_delay = 4;
        applyStimulus(4'b1111, 1'b0, '1);
        drain("post_reset");

        $display("[TB] randomized traffic");
        rand_delay = 1'b1;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(N'($urandom), ($urandom_range(0, 7) == 0), N'($urandom));
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
